// File: rtl/ed25519_pkg.sv
// ed25519_pkg: shared FSM state type and framing constants for the ed25519 host interface and core
package ed25519_pkg;
  localparam int COORD_W     = 255;
  localparam int BEAT_W      = 64;
  localparam int N_IN_BEATS  = 12;
  localparam int N_OUT_BEATS = 8;
  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_e;
endpackage

// File: rtl/ed25519_host_if.sv
// ed25519_host_if: frames one {M,x,y} request into 12 beats for the core and collects 8 result beats
//   i_clk/i_rst                       clock, async active-high reset
//   i_req_valid/o_req_ready/i_M/i_x/i_y   request side
//   o_in_valid/o_in_data/i_in_ready   stream to core
//   i_out_valid/i_out_data/o_out_ready    stream from core
//   o_rsp_valid/i_rsp_ready/o_rx/o_ry response side; o_busy high outside IDLE
module ed25519_host_if
  import ed25519_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [COORD_W-1:0] i_M,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_in_valid,
  output logic [BEAT_W-1:0]  o_in_data,
  input  logic               i_in_ready,
  input  logic               i_out_valid,
  input  logic [BEAT_W-1:0]  i_out_data,
  output logic               o_out_ready,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [COORD_W-1:0] o_rx,
  output logic [COORD_W-1:0] o_ry,
  output logic               o_busy
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [N_IN_BEATS-1:0][BEAT_W-1:0] frame_q, frame_d;
  logic [N_OUT_BEATS-1:0][BEAT_W-1:0] res_q, res_d;
  logic in_valid_q, in_valid_d;
  logic [BEAT_W-1:0] in_data_q, in_data_d;
  logic out_ready_q, out_ready_d;
  logic [3:0] send_idx;
  logic [2:0] recv_idx;
  logic [N_OUT_BEATS*BEAT_W-1:0] res_flat;
  logic unused_pad;
  // beat k lives in packed element (last-k), so the next send beat is one below the current
  assign send_idx = 4'(N_IN_BEATS - 2) - cnt_q;
  assign recv_idx = 3'(N_OUT_BEATS - 1) - cnt_q[2:0];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      res_q       <= '0;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      out_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      res_q       <= res_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      out_ready_q <= out_ready_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    res_d      = res_q;
    in_valid_d = in_valid_q;
    in_data_d  = in_data_q;
    case (state_q)
      IDLE: if (i_req_valid) begin
        state_d    = SEND;
        cnt_d      = '0;
        frame_d    = {1'b0, i_M, 1'b0, i_x, 1'b0, i_y};
        in_valid_d = 1'b1;
        in_data_d  = frame_d[4'(N_IN_BEATS - 1)];
      end
      SEND: if (in_valid_q && i_in_ready) begin
        if (cnt_q == 4'(N_IN_BEATS - 1)) begin
          state_d    = RECV;
          cnt_d      = '0;
          in_valid_d = 1'b0;
        end else begin
          cnt_d     = cnt_q + 4'd1;
          in_data_d = frame_q[send_idx];
        end
      end
      RECV: if (i_out_valid && out_ready_q) begin
        res_d[recv_idx] = i_out_data;
        state_d = (cnt_q == 4'(N_OUT_BEATS - 1)) ? DONE : RECV;
        cnt_d   = (cnt_q == 4'(N_OUT_BEATS - 1)) ? 4'd0 : cnt_q + 4'd1;
      end
      DONE: if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_ready_d = (state_d == RECV);
  end
  assign res_flat    = res_q;
  // the top bit of each 256-bit half is framing padding and never reaches the outputs
  assign unused_pad  = res_flat[2*COORD_W+1] ^ res_flat[COORD_W];
  assign o_rx        = res_flat[2*COORD_W:COORD_W+1];
  assign o_ry        = res_flat[COORD_W-1:0];
  assign o_req_ready = (state_q == IDLE) && !i_rst;
  assign o_in_valid  = in_valid_q;
  assign o_in_data   = in_data_q;
  assign o_out_ready = out_ready_q;
  assign o_rsp_valid = (state_q == DONE);
  assign o_busy      = (state_q != IDLE);
endmodule
